// File: rtl/adder_seq_pkg.sv
// adder_seq_pkg: shared FSM state type and index-width helper for adder_seq_arbiter
package adder_seq_pkg;
  typedef enum logic [1:0] {IDLE, ADD, DONE} state_t;
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
  localparam int NBYTES_DEF = 4;
  localparam int IDX_W = idx_w(NBYTES_DEF);
endpackage

// File: rtl/adder_nbit.sv
// adder_nbit: W-bit ripple-carry adder with carry-out reported as overflow
module adder_nbit #(
  parameter int W = 8
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         carry_in,
  output logic [W-1:0] sum,
  output logic         overflow
);
  logic [W:0] c;
  assign c[0] = carry_in;
  for (genvar i = 0; i < W; i++) begin : g_fa
    assign sum[i]   = a[i] ^ b[i] ^ c[i];
    assign c[i+1]   = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
  end
  assign overflow = c[W];
endmodule

// File: rtl/adder_seq_arbiter.sv
// adder_seq_arbiter: round-robin shares one 8-bit adder between two requesters,
// sequencing W-bit adds one byte per clock, LSB first, carry chained.
module adder_seq_arbiter
  import adder_seq_pkg::*;
#(
  parameter int NBYTES = 4,
  localparam int W = 8 * NBYTES
) (
  input  logic         clk,
  input  logic         n_rst,
  input  logic         req_0,
  input  logic [W-1:0] a_0,
  input  logic [W-1:0] b_0,
  input  logic         cin_0,
  input  logic         req_1,
  input  logic [W-1:0] a_1,
  input  logic [W-1:0] b_1,
  input  logic         cin_1,
  output logic         grant_0,
  output logic         grant_1,
  output logic         busy,
  output logic         done_0,
  output logic         done_1,
  output logic [W-1:0] result,
  output logic         overflow
);
  localparam int IW = idx_w(NBYTES);
  state_t        state, state_nx;
  logic [IW-1:0] idx;
  logic          ptr, owner, carry, win, last, co;
  logic [W-1:0]  op_a, op_b;
  logic [7:0]    byte_a, byte_b, sum8;
  assign win    = (req_0 & req_1) ? ptr : req_1;
  assign last   = idx == IW'(NBYTES - 1);
  assign byte_a = op_a[8*int'(idx) +: 8];
  assign byte_b = op_b[8*int'(idx) +: 8];
  adder_nbit #(.W(8)) u_add (
    .a(byte_a),
    .b(byte_b),
    .carry_in(carry),
    .sum(sum8),
    .overflow(co)
  );
  always_comb begin
    state_nx = IDLE;
    state_nx = (state == IDLE) ? ((req_0 | req_1) ? ADD : IDLE) :
               (state == ADD)  ? (last ? DONE : ADD) : IDLE;
  end
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state    <= IDLE;
      idx      <= '0;
      ptr      <= 1'b0;
      owner    <= 1'b0;
      carry    <= 1'b0;
      op_a     <= '0;
      op_b     <= '0;
      result   <= '0;
      overflow <= 1'b0;
    end else begin
      state <= state_nx;
      if (state == IDLE && (req_0 | req_1)) begin
        owner <= win;
        op_a  <= win ? a_1 : a_0;
        op_b  <= win ? b_1 : b_0;
        carry <= win ? cin_1 : cin_0;
        idx   <= '0;
      end
      if (state == ADD) begin
        result[8*int'(idx) +: 8] <= sum8;
        carry <= co;
        idx   <= idx + 1'b1;
        if (last) overflow <= co;
      end
      // Pointer favours the requester that was not just served.
      if (state == DONE) ptr <= ~owner;
    end
  end
  assign busy    = state != IDLE;
  assign grant_0 = busy & ~owner;
  assign grant_1 = busy & owner;
  assign done_0  = (state == DONE) & ~owner;
  assign done_1  = (state == DONE) & owner;
endmodule

// File: tb/tb_adder_seq_arbiter.sv
// tb_adder_seq_arbiter: directed self-checking bench for adder_seq_arbiter (NBYTES=4)
module tb_adder_seq_arbiter;
  logic        clk = 1'b0;
  logic        n_rst = 1'b0;
  logic        req_0 = 1'b0, req_1 = 1'b0, cin_0 = 1'b0, cin_1 = 1'b0;
  logic [31:0] a_0 = '0, b_0 = '0, a_1 = '0, b_1 = '0;
  logic        grant_0, grant_1, busy, done_0, done_1, overflow;
  logic [31:0] result;
  int          vectors = 0, errors = 0;
  int          cyc, g0, g1, dsum;

  adder_seq_arbiter #(.NBYTES(4)) dut (
    .clk(clk), .n_rst(n_rst),
    .req_0(req_0), .a_0(a_0), .b_0(b_0), .cin_0(cin_0),
    .req_1(req_1), .a_1(a_1), .b_1(b_1), .cin_1(cin_1),
    .grant_0(grant_0), .grant_1(grant_1), .busy(busy),
    .done_0(done_0), .done_1(done_1), .result(result), .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic wait_done(output int c, output int n0, output int n1);
    c = 0;
    n0 = 0;
    n1 = 0;
    do begin
      step();
      c++;
      n0 += int'(grant_0);
      n1 += int'(grant_1);
    end while (!(done_0 || done_1) && c < 20);
  endtask

  initial begin
    #1;
    chk("reset_outputs", {busy, grant_0, grant_1, done_0, done_1, overflow, result}, 0);
    #3 n_rst = 1'b1;
    step();
    chk("idle_after_reset", {busy, grant_0, grant_1}, 0);

    // carry ripples from byte 0 into byte 1
    req_0 = 1'b1; a_0 = 32'h000000FF; b_0 = 32'h00000001; cin_0 = 1'b0;
    wait_done(cyc, g0, g1);
    req_0 = 1'b0;
    chk("t2_latency", cyc, 5);
    chk("t2_done", {done_0, done_1}, 2'b10);
    chk("t2_result", {overflow, result}, {1'b0, 32'h00000100});
    chk("t2_grant_cycles", {g0[7:0], g1[7:0]}, {8'd5, 8'd0});
    step();
    chk("t2_done_pulse", {done_0, busy}, 2'b00);

    // full-width carry chain out of the MSB
    req_1 = 1'b1; a_1 = 32'hFFFFFFFF; b_1 = 32'h00000000; cin_1 = 1'b1;
    wait_done(cyc, g0, g1);
    req_1 = 1'b0;
    chk("t3_done", {done_0, done_1, cyc[7:0]}, {2'b01, 8'd5});
    chk("t3_result", {overflow, result}, {1'b1, 32'h00000000});
    step();
    chk("t3_done_once", {done_1, busy}, 2'b00);

    // asynchronous reset mid-transaction, after result bytes have changed
    req_0 = 1'b1; a_0 = 32'h01010101; b_0 = 32'h01010101; cin_0 = 1'b0;
    step();
    step();
    step();
    #2 n_rst = 1'b0;
    #1;
    chk("t1_async_reset", {busy, grant_0, grant_1, done_0, done_1, overflow, result}, 0);
    req_0 = 1'b0;
    #2 n_rst = 1'b1;
    step();
    chk("t1_idle_after_release", {busy, grant_0, grant_1}, 0);

    // contention after reset: pointer owner (0) wins first
    req_0 = 1'b1; a_0 = 32'h12345678; b_0 = 32'h11111111; cin_0 = 1'b0;
    req_1 = 1'b1; a_1 = 32'h80000000; b_1 = 32'h80000000; cin_1 = 1'b0;
    wait_done(cyc, g0, g1);
    req_0 = 1'b0;
    chk("t4_first_done", {done_0, done_1, cyc[7:0]}, {2'b10, 8'd5});
    chk("t4_first_result", {overflow, result}, {1'b0, 32'h23456789});
    wait_done(cyc, g0, g1);
    req_1 = 1'b0;
    chk("t4_second_done", {done_0, done_1, cyc[7:0]}, {2'b01, 8'd6});
    chk("t4_second_result", {overflow, result}, {1'b1, 32'h00000000});
    step();

    // operands latched at grant; req drop and operand change ignored
    req_0 = 1'b1; a_0 = 32'h01020304; b_0 = 32'h10203040; cin_0 = 1'b1;
    step();
    step();
    req_0 = 1'b0; a_0 = 32'hFFFFFFFF; b_0 = 32'hFFFFFFFF; cin_0 = 1'b0;
    wait_done(cyc, g0, g1);
    chk("t5_done", {done_0, done_1, cyc[7:0]}, {2'b10, 8'd3});
    chk("t5_result", {overflow, result}, {1'b0, 32'h11223345});
    step();
    chk("t5_pulse_end", {done_0, busy}, 2'b00);

    // repeat contention: requester 0 was served last, so 1 goes first
    req_0 = 1'b1; a_0 = 32'h12345678; b_0 = 32'h11111111; cin_0 = 1'b0;
    req_1 = 1'b1; a_1 = 32'h80000000; b_1 = 32'h80000000; cin_1 = 1'b0;
    wait_done(cyc, g0, g1);
    req_1 = 1'b0;
    chk("t4r_first_done", {done_0, done_1, cyc[7:0]}, {2'b01, 8'd5});
    chk("t4r_first_result", {overflow, result}, {1'b1, 32'h00000000});
    wait_done(cyc, g0, g1);
    req_0 = 1'b0;
    chk("t4r_second_done", {done_0, done_1, cyc[7:0]}, {2'b10, 8'd6});
    chk("t4r_second_result", {overflow, result}, {1'b0, 32'h23456789});
    step();

    // reset during byte-2 ADD cycle aborts with no done
    req_0 = 1'b1; a_0 = 32'hAAAAAAAA; b_0 = 32'h11111111; cin_0 = 1'b0;
    step();
    step();
    step();
    #2 n_rst = 1'b0;
    #1;
    req_0 = 1'b0;
    chk("t6_reset_outputs", {busy, grant_0, grant_1, done_0, done_1, overflow, result}, 0);
    #2 n_rst = 1'b1;
    dsum = 0;
    for (int i = 0; i < 8; i++) begin
      step();
      dsum += int'(done_0) + int'(done_1) + int'(busy);
    end
    chk("t6_no_done", dsum, 0);
    req_0 = 1'b1; a_0 = 32'h0000FFFF; b_0 = 32'h00000001; cin_0 = 1'b0;
    wait_done(cyc, g0, g1);
    req_0 = 1'b0;
    chk("t6_done", {done_0, done_1, cyc[7:0]}, {2'b10, 8'd5});
    chk("t6_result", {overflow, result}, {1'b0, 32'h00010000});
    step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
